// File: rtl/tlb_update_unit_pkg.sv
// ----------------------------------------------------------------------------
// tlb_update_unit_pkg
//   Shared TLB types and constants for the TLB update path and the MMU:
//   entry layout, write/invalidate request payloads, INVTLB op encodings and
//   the huge-page size code.
//   Entry count defaults to 32.
// ----------------------------------------------------------------------------
package tlb_update_unit_pkg;

    localparam int TLB_ENTRY_NUM_DEF = 32;
    localparam int TLB_IDX_W = $clog2(TLB_ENTRY_NUM_DEF);

    // Page size code of a huge (2 MiB) page; such entries match on vppn[18:9].
    localparam logic [5:0] PS_HUGE = 6'd21;

    // INVTLB op encodings
    localparam logic [4:0] INV_ALL0         = 5'd0;
    localparam logic [4:0] INV_ALL1         = 5'd1;
    localparam logic [4:0] INV_G1           = 5'd2;
    localparam logic [4:0] INV_G0           = 5'd3;
    localparam logic [4:0] INV_G0_ASID      = 5'd4;
    localparam logic [4:0] INV_G0_ASID_VA   = 5'd5;
    localparam logic [4:0] INV_G_OR_ASID_VA = 5'd6;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        logic [19:0] ppn0;
        logic [19:0] ppn1;
    } tlb_entry_t;

    typedef struct packed {
        logic [TLB_IDX_W-1:0] idx;
        tlb_entry_t           entry;
    } tlb_w_req_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [9:0]  asid;
        logic [18:0] vppn;
    } tlb_inv_req_t;

endpackage

// File: rtl/tlb_update_unit_if.sv
// ----------------------------------------------------------------------------
// tlb_update_unit_if
//   Request channel from the MMU into the TLB update unit.
//   w_valid/w_req/w_ready       : TLBWR/TLBFILL write request handshake
//   inv_valid/inv_req/inv_ready : INVTLB request handshake
//   master modport = MMU (request producer), slave modport = update unit.
// ----------------------------------------------------------------------------
interface tlb_update_unit_if
    import tlb_update_unit_pkg::*;
    ();

    logic         w_valid;
    tlb_w_req_t   w_req;
    logic         w_ready;
    logic         inv_valid;
    tlb_inv_req_t inv_req;
    logic         inv_ready;

    modport master (
        output w_valid, w_req, inv_valid, inv_req,
        input  w_ready, inv_ready
    );

    modport slave (
        input  w_valid, w_req, inv_valid, inv_req,
        output w_ready, inv_ready
    );

endinterface

// File: rtl/tlb_update_unit_inv_match.sv
// ----------------------------------------------------------------------------
// tlb_inv_match
//   Combinational INVTLB match of one TLB entry against (op, asid, vppn).
//   Also usable for TLBSRCH-style lookups in the MMU.
//   i_ent_e/g/asid/ps/vppn : fields of the entry under test
//   i_op, i_asid, i_vppn   : invalidate operands
//   o_hit                  : entry is valid and selected by op
// ----------------------------------------------------------------------------
module tlb_inv_match
    import tlb_update_unit_pkg::*;
(
    input  logic        i_ent_e,
    input  logic        i_ent_g,
    input  logic [9:0]  i_ent_asid,
    input  logic [5:0]  i_ent_ps,
    input  logic [18:0] i_ent_vppn,
    input  logic [4:0]  i_op,
    input  logic [9:0]  i_asid,
    input  logic [18:0] i_vppn,
    output logic        o_hit
);

    logic w_va_hit;
    logic w_asid_hit;
    logic w_sel;

    always_comb begin
        // Huge pages ignore the low 9 vppn bits (they index within the page).
        if (i_ent_ps == PS_HUGE)
            w_va_hit = (i_ent_vppn[18:9] == i_vppn[18:9]);
        else
            w_va_hit = (i_ent_vppn == i_vppn);

        w_asid_hit = (i_ent_asid == i_asid);

        case (i_op)
            INV_ALL0, INV_ALL1: w_sel = 1'b1;
            INV_G1:             w_sel = i_ent_g;
            INV_G0:             w_sel = ~i_ent_g;
            INV_G0_ASID:        w_sel = ~i_ent_g & w_asid_hit;
            INV_G0_ASID_VA:     w_sel = ~i_ent_g & w_asid_hit & w_va_hit;
            INV_G_OR_ASID_VA:   w_sel = (i_ent_g | w_asid_hit) & w_va_hit;
            // Illegal ops select nothing; the exception is raised upstream.
            default:            w_sel = 1'b0;
        endcase

        // Invalid entries are never touched.
        o_hit = i_ent_e & w_sel;
    end

endmodule

// File: rtl/tlb_update_unit.sv
// ----------------------------------------------------------------------------
// tlb_update_unit
//   Applies TLBWR/TLBFILL writes and INVTLB invalidations to TLB storage.
//   INVTLB walks all entries one per cycle and clears E of each match.
//   Optional feature macro: TLB_INV_FLASH_CLR_EN -- op0/op1 become a one-cycle
//   flash clear instead of a walk.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : write / invalidate request handshakes
//   rd_idx_o        : storage read index (combinational read)
//   rd_entry_i      : entry at rd_idx_o, same cycle
//   wr_en_o/wr_idx_o/wr_entry_o : registered storage write port
//   flash_clr_o     : clear E of all entries (0 unless flash feature enabled)
//   busy_o          : update in flight, pipeline stalls
//   done_o          : one-cycle pulse on final write/flash of each request
// ----------------------------------------------------------------------------
module tlb_update_unit
    import tlb_update_unit_pkg::*;
#(
    parameter  int TLB_ENTRY_NUM = TLB_ENTRY_NUM_DEF,
    localparam int INDEX_LEN     = $clog2(TLB_ENTRY_NUM)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    tlb_update_unit_if.slave     bus,
    output logic [INDEX_LEN-1:0] rd_idx_o,
    input  tlb_entry_t           rd_entry_i,
    output logic                 wr_en_o,
    output logic [INDEX_LEN-1:0] wr_idx_o,
    output tlb_entry_t           wr_entry_o,
    output logic                 flash_clr_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic {S_IDLE, S_WALK} state_t;

    localparam logic [INDEX_LEN-1:0] LAST_IDX = INDEX_LEN'(TLB_ENTRY_NUM - 1);

    state_t               r_state;
    logic [INDEX_LEN-1:0] r_idx;
    tlb_inv_req_t         r_inv;
    logic                 r_wr_en;
    logic [INDEX_LEN-1:0] r_wr_idx;
    tlb_entry_t           r_wr_entry;
    logic                 r_done;
    logic                 w_flash_q;

    state_t               w_state_nxt;
    logic [INDEX_LEN-1:0] w_idx_nxt;
    tlb_inv_req_t         w_inv_nxt;
    logic                 w_wr_en_nxt;
    logic [INDEX_LEN-1:0] w_wr_idx_nxt;
    tlb_entry_t           w_wr_entry_nxt;
    logic                 w_done_nxt;

    logic w_free;
    logic w_w_acc;
    logic w_inv_acc;
    logic w_inv_flash;
    logic w_hit;
    logic w_last;

    // A request is only taken when idle and the previous registered write
    // (or flash) has drained, so accepted requests are >= 2 cycles apart.
    assign w_free        = (r_state == S_IDLE) & ~r_wr_en & ~w_flash_q;
    assign bus.w_ready   = w_free;
    // Writes win a tie; the invalidate stays pending.
    assign bus.inv_ready = w_free & ~bus.w_valid;
    assign w_w_acc       = bus.w_valid & bus.w_ready;
    assign w_inv_acc     = bus.inv_valid & bus.inv_ready;
    assign w_last        = (r_idx == LAST_IDX);

`ifdef TLB_INV_FLASH_CLR_EN
    logic r_flash;

    assign w_inv_flash = w_inv_acc &
                         ((bus.inv_req.op == INV_ALL0) | (bus.inv_req.op == INV_ALL1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_flash <= 1'b0;
        else        r_flash <= w_inv_flash;
    end

    assign w_flash_q   = r_flash;
    assign flash_clr_o = r_flash;
`else
    assign w_inv_flash = 1'b0;
    assign w_flash_q   = 1'b0;
    assign flash_clr_o = 1'b0;
`endif

    tlb_inv_match u_match (
        .i_ent_e    (rd_entry_i.e),
        .i_ent_g    (rd_entry_i.g),
        .i_ent_asid (rd_entry_i.asid),
        .i_ent_ps   (rd_entry_i.ps),
        .i_ent_vppn (rd_entry_i.vppn),
        .i_op       (r_inv.op),
        .i_asid     (r_inv.asid),
        .i_vppn     (r_inv.vppn),
        .o_hit      (w_hit)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_inv_nxt      = r_inv;
        w_wr_en_nxt    = 1'b0;
        w_wr_idx_nxt   = r_wr_idx;
        w_wr_entry_nxt = r_wr_entry;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_w_acc) begin
                    w_wr_en_nxt    = 1'b1;
                    w_wr_idx_nxt   = INDEX_LEN'(bus.w_req.idx);
                    w_wr_entry_nxt = bus.w_req.entry;
                    w_done_nxt     = 1'b1;
                end else if (w_inv_flash) begin
                    w_done_nxt     = 1'b1;
                end else if (w_inv_acc) begin
                    w_inv_nxt      = bus.inv_req;
                    w_idx_nxt      = '0;
                    w_state_nxt    = S_WALK;
                end
            end
            S_WALK: begin
                // Write-back of entry k lands while k+1 is being read; the
                // indices differ, so no read-after-write hazard exists.
                if (w_hit) begin
                    w_wr_en_nxt      = 1'b1;
                    w_wr_idx_nxt     = r_idx;
                    w_wr_entry_nxt   = rd_entry_i;
                    w_wr_entry_nxt.e = 1'b0;
                end
                // Stop at N-1 explicitly so non-power-of-2 N never wraps.
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_idx_nxt   = r_idx + INDEX_LEN'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_inv      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_idx   <= '0;
            r_wr_entry <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_inv      <= w_inv_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_idx   <= w_wr_idx_nxt;
            r_wr_entry <= w_wr_entry_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign rd_idx_o   = r_idx;
    assign wr_en_o    = r_wr_en;
    assign wr_idx_o   = r_wr_idx;
    assign wr_entry_o = r_wr_entry;
    assign done_o     = r_done;
    // Busy covers the whole walk plus the completion cycle of any request.
    assign busy_o     = (r_state == S_WALK) | r_done;

endmodule

// File: tb/tb_tlb_update_unit.sv
module tb_tlb_update_unit;
    import tlb_update_unit_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlb_update_unit_if bus ();

    logic [4:0] rd_idx;
    tlb_entry_t rd_entry;
    logic       wr_en;
    logic [4:0] wr_idx;
    tlb_entry_t wr_entry;
    logic       flash_clr;
    logic       busy;
    logic       done;

    tlb_entry_t mem [N];
    assign rd_entry = mem[rd_idx];

    tlb_update_unit #(.TLB_ENTRY_NUM(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .rd_idx_o    (rd_idx),
        .rd_entry_i  (rd_entry),
        .wr_en_o     (wr_en),
        .wr_idx_o    (wr_idx),
        .wr_entry_o  (wr_entry),
        .flash_clr_o (flash_clr),
        .busy_o      (busy),
        .done_o      (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         wr_cyc_q [$];
    logic [4:0] wr_idx_q [$];
    tlb_entry_t wr_ent_q [$];
    int         done_q   [$];
    int         flash_q  [$];

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cyc_q.push_back(cyc);
            wr_idx_q.push_back(wr_idx);
            wr_ent_q.push_back(wr_entry);
        end
        if (done)      done_q.push_back(cyc);
        if (flash_clr) flash_q.push_back(cyc);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tlb_entry_t mk(input logic e, input logic g, input logic [9:0] asid,
                                      input logic [5:0] ps, input logic [18:0] vppn);
        tlb_entry_t r;
        r.vppn = vppn;
        r.ps   = ps;
        r.g    = g;
        r.asid = asid;
        r.e    = e;
        r.ppn0 = {1'b0, vppn};
        r.ppn1 = 20'hABCDE;
        return r;
    endfunction

    function automatic tlb_entry_t cleared(input tlb_entry_t x);
        tlb_entry_t r;
        r   = x;
        r.e = 1'b0;
        return r;
    endfunction

    task automatic wait_acc(input bit inv, output int t);
        t = -1;
        for (int i = 0; i < 100; i++) begin
            if (inv ? (bus.inv_valid & bus.inv_ready) : (bus.w_valid & bus.w_ready)) begin
                t = cyc;
                break;
            end
            @(negedge clk); #1;
        end
        check(inv ? "inv_accept" : "w_accept", (t >= 0), 1'b1);
        @(posedge clk); #1;
        if (inv) bus.inv_valid = 1'b0;
        else     bus.w_valid   = 1'b0;
    endtask

    task automatic send_w(input logic [4:0] idx, input tlb_entry_t e, output int t);
        @(negedge clk);
        bus.w_req.idx   = idx;
        bus.w_req.entry = e;
        bus.w_valid     = 1'b1;
        #1;
        wait_acc(1'b0, t);
    endtask

    task automatic send_inv(input logic [4:0] op, input logic [9:0] asid,
                            input logic [18:0] vppn, output int t);
        @(negedge clk);
        bus.inv_req.op   = op;
        bus.inv_req.asid = asid;
        bus.inv_req.vppn = vppn;
        bus.inv_valid    = 1'b1;
        #1;
        wait_acc(1'b1, t);
    endtask

    task automatic wait_done(input int base, output int d);
        d = -1;
        for (int i = 0; i < 100; i++) begin
            if (done_q.size() > base) begin
                d = done_q[base];
                break;
            end
            @(negedge clk); #1;
        end
        check("done_seen", (d >= 0), 1'b1);
        repeat (4) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, d, d2, bw, bd, bf;
        tlb_entry_t ent7;
        logic [4:0] rst_op;

        bus.w_valid   = 1'b0;
        bus.inv_valid = 1'b0;
        bus.w_req     = '0;
        bus.inv_req   = '0;
        for (int i = 0; i < N; i++) mem[i] = mk(1'b0, 1'b0, 10'h0, 6'd12, 19'h0);

        // reset state
        #1;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_flash", flash_clr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_idx", wr_idx, 5'd0);
        check("rst_wr_entry", wr_entry, '0);
        check("rst_rd_idx", rd_idx, 5'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // TLBWR to index 7
        ent7 = mk(1'b1, 1'b1, 10'h55, 6'd12, 19'h4abc);
        bw = wr_idx_q.size(); bd = done_q.size();
        send_w(5'd7, ent7, t);
        check("w_inv_ready_low", bus.inv_ready, 1'b0);
        check("w_w_ready_low", bus.w_ready, 1'b0);
        check("w_busy_t1", busy, 1'b1);
        check("w_wr_en_t1", wr_en, 1'b1);
        check("w_wr_idx_t1", wr_idx, 5'd7);
        @(posedge clk); #1;
        check("w_busy_t2", busy, 1'b0);
        wait_done(bd, d);
        check("w_done_lat", d - t, 1);
        check("w_count", wr_idx_q.size() - bw, 1);
        check("w_entry", wr_ent_q[bw], ent7);
        check("w_wr_cyc", wr_cyc_q[bw] - t, 1);
        check("w_done_count", done_q.size() - bd, 1);

        // op2: global entries 3 and 30
        for (int i = 0; i < N; i++)
            mem[i] = mk(1'b1, (i == 3 || i == 30), 10'h1, 6'd12, 19'(i));
        bw = wr_idx_q.size(); bd = done_q.size();
        send_inv(5'd2, 10'h0, 19'h0, t);
        check("op2_busy", busy, 1'b1);
        wait_done(bd, d);
        check("op2_count", wr_idx_q.size() - bw, 2);
        check("op2_idx0", wr_idx_q[bw], 5'd3);
        check("op2_idx1", wr_idx_q[bw+1], 5'd30);
        check("op2_ent0", wr_ent_q[bw], cleared(mem[3]));
        check("op2_ent1", wr_ent_q[bw+1], cleared(mem[30]));
        check("op2_e0", wr_ent_q[bw].e, 1'b0);
        check("op2_done_lat", d - t, 33);
        check("op2_done_count", done_q.size() - bd, 1);
        check("op2_busy_end", busy, 1'b0);

        // op5: asid 0x12, vppn 0x12345
        for (int i = 0; i < N; i++) mem[i] = mk(1'b1, 1'b0, 10'h12, 6'd12, 19'h0);
        mem[10] = mk(1'b1, 1'b0, 10'h12, 6'd12, 19'h12345);
        mem[11] = mk(1'b1, 1'b0, 10'h13, 6'd12, 19'h12345);
        mem[12] = mk(1'b1, 1'b0, 10'h12, 6'd21, 19'h12300);
        mem[13] = mk(1'b0, 1'b0, 10'h12, 6'd12, 19'h12345);
        mem[14] = mk(1'b1, 1'b1, 10'h12, 6'd12, 19'h12345);
        mem[15] = mk(1'b1, 1'b0, 10'h12, 6'd12, 19'h12344);
        bw = wr_idx_q.size(); bd = done_q.size();
        send_inv(5'd5, 10'h12, 19'h12345, t);
        wait_done(bd, d);
        check("op5_count", wr_idx_q.size() - bw, 2);
        check("op5_idx0", wr_idx_q[bw], 5'd10);
        check("op5_idx1", wr_idx_q[bw+1], 5'd12);
        check("op5_ent1", wr_ent_q[bw+1], cleared(mem[12]));

        // simultaneous write and invalidate
        for (int i = 0; i < N; i++) mem[i] = mk(1'b0, 1'b0, 10'h0, 6'd12, 19'h0);
        bw = wr_idx_q.size(); bd = done_q.size();
        @(negedge clk);
        bus.w_req.idx    = 5'd5;
        bus.w_req.entry  = ent7;
        bus.inv_req.op   = 5'd3;
        bus.inv_req.asid = 10'h0;
        bus.inv_req.vppn = 19'h0;
        bus.w_valid      = 1'b1;
        bus.inv_valid    = 1'b1;
        #1;
        check("sim_w_ready", bus.w_ready, 1'b1);
        check("sim_inv_ready", bus.inv_ready, 1'b0);
        t = cyc;
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
        wait_acc(1'b1, t2);
        check("sim_inv_gap", t2 - t, 2);
        wait_done(bd + 1, d2);
        check("sim_done_count", done_q.size() - bd, 2);
        check("sim_done0", done_q[bd] - t, 1);
        check("sim_done1", d2 - t2, 33);
        check("sim_wr_count", wr_idx_q.size() - bw, 1);
        check("sim_wr_idx", wr_idx_q[bw], 5'd5);

        // illegal op 9
        for (int i = 0; i < N; i++) mem[i] = mk(1'b1, 1'b1, 10'h0, 6'd12, 19'h0);
        bw = wr_idx_q.size(); bd = done_q.size();
        send_inv(5'd9, 10'h0, 19'h0, t);
        wait_done(bd, d);
        check("op9_count", wr_idx_q.size() - bw, 0);
        check("op9_done_count", done_q.size() - bd, 1);
        check("op9_done_lat", d - t, 33);

        // op1
        bw = wr_idx_q.size(); bd = done_q.size(); bf = flash_q.size();
        send_inv(5'd1, 10'h0, 19'h0, t);
        wait_done(bd, d);
`ifdef TLB_INV_FLASH_CLR_EN
        check("op1_flash_count", flash_q.size() - bf, 1);
        check("op1_flash_cyc", flash_q[bf] - t, 1);
        check("op1_done_lat", d - t, 1);
        check("op1_wr_count", wr_idx_q.size() - bw, 0);
`else
        check("op1_flash_count", flash_q.size() - bf, 0);
        check("op1_wr_count", wr_idx_q.size() - bw, 32);
        check("op1_first_idx", wr_idx_q[bw], 5'd0);
        check("op1_last_idx", wr_idx_q[bw+31], 5'd31);
        check("op1_done_lat", d - t, 33);
`endif

        // reset mid-walk at k=5
        for (int i = 0; i < N; i++) mem[i] = mk(1'b1, 1'b0, 10'h0, 6'd12, 19'h0);
`ifdef TLB_INV_FLASH_CLR_EN
        rst_op = 5'd3;
`else
        rst_op = 5'd0;
`endif
        send_inv(rst_op, 10'h0, 19'h0, t);
        for (int i = 0; i < 20; i++) begin
            if (cyc == t + 6) break;
            @(negedge clk); #1;
        end
        check("mid_rd_idx", rd_idx, 5'd5);
        check("mid_wr_en", wr_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mrst_wr_en", wr_en, 1'b0);
        check("mrst_flash", flash_clr, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_wr_idx", wr_idx, 5'd0);
        check("mrst_wr_entry", wr_entry, '0);
        check("mrst_rd_idx", rd_idx, 5'd0);
        bw = wr_idx_q.size(); bd = done_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("mrst_no_writes", wr_idx_q.size() - bw, 0);
        check("mrst_no_done", done_q.size() - bd, 0);
        check("mrst_idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
